// File: rtl/lcd_serial_receiver.sv
// rtl/lcd_serial_receiver.sv - serial LCD bus snooper with byte FIFO, overflow and frame tracking
module lcd_serial_receiver #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] lcd_in,
    output logic [7:0] rd_data,
    output logic       rd_dc,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       overflow,
    input  logic       clr_ovf,
    output logic       frame_abort,
    output logic [7:0] frame_bytes
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // lcd_in = {CS, SCL, A0, SI}; idle bus is CS high, SCL high
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic       scl_prev;
    logic       cs_prev;

    logic       cs_s;
    logic       scl_s;
    logic       a0_s;
    logic       si_s;

    assign cs_s  = sync2[3];
    assign scl_s = sync2[2];
    assign a0_s  = sync2[1];
    assign si_s  = sync2[0];

    logic [7:0] shreg;
    logic [2:0] bit_cnt;

    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic scl_rise;
    logic cs_rise;
    logic cs_fall;
    logic shift_en;
    logic push_req;
    logic full;
    logic pop;
    logic push_ok;

    assign scl_rise = scl_s & ~scl_prev;
    assign cs_rise  = cs_s & ~cs_prev;
    assign cs_fall  = ~cs_s & cs_prev;
    assign shift_en = scl_rise & ~cs_s;
    assign push_req = shift_en & (bit_cnt == 3'd7);
    assign full     = (count == FULL_CNT);
    assign rd_valid = (count != '0);
    assign pop      = rd_valid & rd_ready;
    // a full FIFO still accepts when the head leaves in the same cycle
    assign push_ok  = push_req & (~full | pop);
    assign rd_data  = mem[rd_ptr][7:0];
    assign rd_dc    = mem[rd_ptr][8];

    // two-flop synchronizers plus edge-detect history for SCL and CS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 4'b1100;
            sync2    <= 4'b1100;
            scl_prev <= 1'b1;
            cs_prev  <= 1'b1;
        end else begin
            sync1    <= lcd_in;
            sync2    <= sync1;
            scl_prev <= scl_s;
            cs_prev  <= cs_s;
        end
    end

    // MSB-first shifter; a CS rise throws away whatever partial byte is held
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= 8'h00;
            bit_cnt <= 3'd0;
        end else if (cs_rise) begin
            shreg   <= 8'h00;
            bit_cnt <= 3'd0;
        end else if (shift_en) begin
            shreg   <= {shreg[6:0], si_s};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // FIFO storage and pointers; entry is {A0, byte}
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 9'h000;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= {a0_s, shreg[6:0], si_s};
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // occupancy count; simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // sticky overflow; a new drop wins over a coincident clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push_req && full && !pop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // frame bookkeeping: abort pulse on a cut-short byte, saturating byte count per frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_abort <= 1'b0;
            frame_bytes <= 8'h00;
        end else begin
            frame_abort <= cs_rise && (bit_cnt != 3'd0);
            if (cs_fall) begin
                frame_bytes <= 8'h00;
            end else if (push_req && (frame_bytes != 8'hFF)) begin
                frame_bytes <= frame_bytes + 8'h01;
            end
        end
    end

endmodule

// File: tb/tb_lcd_serial_receiver.sv
// tb/tb_lcd_serial_receiver.sv - directed self-checking bench for lcd_serial_receiver
module tb_lcd_serial_receiver;

    logic       clk;
    logic       rst_n;
    logic [3:0] lcd_in;
    logic [7:0] rd_data;
    logic       rd_dc;
    logic       rd_valid;
    logic       rd_ready;
    logic       overflow;
    logic       clr_ovf;
    logic       frame_abort;
    logic [7:0] frame_bytes;

    logic cs;
    logic scl;
    logic a0;
    logic si;

    int errors = 0;
    int checks = 0;
    int abort_cnt = 0;
    logic [8:0] pop_q[$];

    assign lcd_in = {cs, scl, a0, si};

    lcd_serial_receiver #(.FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .lcd_in      (lcd_in),
        .rd_data     (rd_data),
        .rd_dc       (rd_dc),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf),
        .frame_abort (frame_abort),
        .frame_bytes (frame_bytes)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // record every accepted entry and every abort pulse, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_ready) pop_q.push_back({rd_dc, rd_data});
        if (frame_abort) abort_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // hook 1: clr_ovf high on the push cycle of the last bit; hook 2: rd_ready high on that cycle
    task automatic send_byte(input logic [7:0] b, input int hook);
        for (int i = 7; i >= 0; i--) begin
            si  = b[i];
            scl = 1'b0;
            tick(10);
            scl = 1'b1;
            if (i == 0 && hook != 0) begin
                tick(2);
                if (hook == 1) clr_ovf = 1'b1; else rd_ready = 1'b1;
                tick(1);
                clr_ovf  = 1'b0;
                rd_ready = 1'b0;
                tick(7);
            end else begin
                tick(10);
            end
        end
    endtask

    task automatic cs_low();
        cs = 1'b0;
        tick(4);
    endtask

    task automatic cs_high();
        tick(4);
        cs = 1'b1;
        tick(6);
    endtask

    task automatic check_pop(input string tag, input int idx, input logic [8:0] exp);
        logic [8:0] got;
        got = (idx < pop_q.size()) ? pop_q[idx] : 9'h1xx;
        check(tag, {23'd0, got}, {23'd0, exp});
    endtask

    initial begin
        rst_n = 1'b0; rd_ready = 1'b0; clr_ovf = 1'b0;
        cs = 1'b1; scl = 1'b1; a0 = 1'b0; si = 1'b0;
        tick(3);
        check("rst_valid", {31'd0, rd_valid}, 0);
        check("rst_data", {24'd0, rd_data}, 0);
        check("rst_dc", {31'd0, rd_dc}, 0);
        check("rst_ovf", {31'd0, overflow}, 0);
        check("rst_abort", {31'd0, frame_abort}, 0);
        check("rst_fbytes", {24'd0, frame_bytes}, 0);
        rst_n = 1'b1;
        tick(4);

        // single data byte streamed straight out
        rd_ready = 1'b1; a0 = 1'b1;
        cs_low();
        send_byte(8'hA5, 0);
        cs_high();
        check("t1_npop", pop_q.size(), 1);
        check_pop("t1_entry", 0, 9'h1A5);
        check("t1_fbytes", {24'd0, frame_bytes}, 1);
        check("t1_valid_after", {31'd0, rd_valid}, 0);

        // partial byte cut by CS rise, then a clean frame
        pop_q.delete(); a0 = 1'b0;
        cs_low();
        for (int i = 0; i < 5; i++) begin
            si = 1'b1; scl = 1'b0; tick(10); scl = 1'b1; tick(10);
        end
        cs_high();
        check("t3_abort_cnt", abort_cnt, 1);
        check("t3_nopush", {31'd0, rd_valid}, 0);
        check("t3_npop", pop_q.size(), 0);
        cs_low();
        send_byte(8'h3C, 0);
        cs_high();
        check("t3_npop2", pop_q.size(), 1);
        check_pop("t3_entry", 0, 9'h03C);
        check("t3_abort_cnt2", abort_cnt, 1);
        check("t3_fbytes", {24'd0, frame_bytes}, 1);

        // fill past depth with no consumer
        pop_q.delete(); rd_ready = 1'b0;
        cs_low();
        for (int b = 1; b <= 5; b++) send_byte(8'(b), 0);
        cs_high();
        check("t2_ovf", {31'd0, overflow}, 1);
        check("t2_fbytes", {24'd0, frame_bytes}, 5);
        check("t2_valid", {31'd0, rd_valid}, 1);
        check("t2_head", {23'd0, rd_dc, rd_data}, 9'h001);
        tick(5);
        check("t2_head_stable", {23'd0, rd_dc, rd_data}, 9'h001);

        // clear on its own
        clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;
        check("t5_clr", {31'd0, overflow}, 0);

        rd_ready = 1'b1; tick(8); rd_ready = 1'b0;
        check("t2_npop", pop_q.size(), 4);
        for (int i = 0; i < 4; i++) check_pop($sformatf("t2_pop%0d", i), i, 9'(i + 1));
        check("t2_empty", {31'd0, rd_valid}, 0);

        // full FIFO with pop on the completing cycle
        pop_q.delete();
        cs_low();
        for (int b = 0; b < 4; b++) send_byte(8'h10 + 8'(b), 0);
        send_byte(8'h14, 2);
        cs_high();
        check("t4_ovf", {31'd0, overflow}, 0);
        check("t4_npop1", pop_q.size(), 1);
        check_pop("t4_pop_head", 0, 9'h010);
        check("t4_valid", {31'd0, rd_valid}, 1);
        rd_ready = 1'b1; tick(8); rd_ready = 1'b0;
        check("t4_npop", pop_q.size(), 5);
        for (int i = 1; i < 5; i++) check_pop($sformatf("t4_pop%0d", i), i, 9'h010 + 9'(i));

        // clear coinciding with a fresh drop keeps overflow set
        pop_q.delete();
        cs_low();
        for (int b = 0; b < 4; b++) send_byte(8'h20 + 8'(b), 0);
        check("t5_pre_ovf", {31'd0, overflow}, 0);
        send_byte(8'h24, 1);
        cs_high();
        check("t5_coincide", {31'd0, overflow}, 1);
        rd_ready = 1'b1; tick(8); rd_ready = 1'b0;
        check("t5_npop", pop_q.size(), 4);
        for (int i = 0; i < 4; i++) check_pop($sformatf("t5_pop%0d", i), i, 9'h020 + 9'(i));
        clr_ovf = 1'b1; tick(1); clr_ovf = 1'b0;

        // reset mid-byte, then a clean byte with no residue
        pop_q.delete(); a0 = 1'b1;
        cs_low();
        for (int i = 0; i < 3; i++) begin
            si = i[0] ? 1'b0 : 1'b1; scl = 1'b0; tick(10); scl = 1'b1; tick(10);
        end
        rst_n = 1'b0;
        tick(3);
        check("t6_rst_fbytes", {24'd0, frame_bytes}, 0);
        check("t6_rst_valid", {31'd0, rd_valid}, 0);
        rst_n = 1'b1;
        cs = 1'b1;
        tick(6);
        rd_ready = 1'b1;
        cs_low();
        send_byte(8'h81, 0);
        cs_high();
        check("t6_npop", pop_q.size(), 1);
        check_pop("t6_entry", 0, 9'h181);
        check("t6_fbytes", {24'd0, frame_bytes}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_serial_receiver.md
LCD_SERIAL_RECEIVER -- requirements
Module: lcd_serial_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of received-byte entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, 50 MHz system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port lcd_in, input, 4, serial LCD bus {CS, SCL, A0, SI}, asynchronous to clk, CS active-low.
REQ-005 SHALL have port rd_data, output, 8, byte at FIFO head.
REQ-006 SHALL have port rd_dc, output, 1, A0 value captured with rd_data (0 command, 1 data).
REQ-007 SHALL have port rd_valid, output, 1, FIFO non-empty.
REQ-008 SHALL have port rd_ready, input, 1, consumer accepts head entry.
REQ-009 SHALL have port overflow, output, 1, sticky: a completed byte was dropped.
REQ-010 SHALL have port clr_ovf, input, 1, synchronous clear of overflow.
REQ-011 SHALL have port frame_abort, output, 1, one-cycle pulse: CS rose with a partial byte.
REQ-012 SHALL have port frame_bytes, output, 8, bytes completed in current/last CS frame, saturating at 255.

Function
REQ-013 SHALL pass each lcd_in bit through a two-flop synchronizer before any use.
REQ-014 SHALL detect SCL rising edge as synchronized SCL = 1 while its previous registered value = 0.
REQ-015 SHALL, while synchronized CS = 0, on each detected SCL rising edge shift synchronized SI into an 8-bit register MSB first and increment a 3-bit bit counter.
REQ-016 SHALL ignore SCL edges while synchronized CS = 1.
REQ-017 SHALL, on the edge that brings the bit counter from 7 to 0, form {A0, byte} using the synchronized A0 at that edge and push it into the FIFO in the same clk cycle.
REQ-018 SHALL make rd_valid high the cycle after a push into an empty FIFO; total latency from SCL pin edge to rd_valid high SHALL NOT exceed 4 clk cycles.
REQ-019 SHALL pop the head entry on every cycle with rd_valid = 1 and rd_ready = 1; rd_data/rd_dc SHALL be stable while rd_valid = 1 and rd_ready = 0.
REQ-020 SHALL, on simultaneous push and pop, perform both with count unchanged, including when full.
REQ-021 SHALL, on push when full without pop, discard the new entry, keep FIFO contents, and set overflow the following cycle.
REQ-022 SHALL clear overflow on clr_ovf = 1; if a set condition coincides with clr_ovf, overflow SHALL remain 1.
REQ-023 SHALL, on synchronized CS rising edge with bit counter != 0, clear the bit counter, discard the partial byte, and pulse frame_abort for exactly one cycle.
REQ-024 SHALL clear the bit counter on any CS rising edge, without frame_abort when counter = 0.
REQ-025 SHALL reset frame_bytes to 0 on synchronized CS falling edge and increment it on each completed byte (including dropped ones), saturating at 255; value holds after CS rises.
REQ-026 SHALL use wrap-around read/write pointers of log2(FIFO_DEPTH) bits plus a count register for full/empty.

Reset
REQ-027 SHALL, while rst_n = 0, force synchronizers to CS=1, SCL=1, A0=0, SI=0, shift register and bit counter to 0, FIFO empty, rd_valid=0, rd_data=0x00, rd_dc=0, overflow=0, frame_abort=0, frame_bytes=0.
REQ-028 SHALL, on reset asserted mid-byte, discard all partial and buffered data; after release, reception SHALL start only at the next CS falling edge with bit counter 0.

Verification
REQ-029 SHALL test: CS low, A0=1, send 0xA5 with SCL period 20 clk, rd_ready=1 -> one rd_valid pulse, rd_data=0xA5, rd_dc=1, frame_bytes=1.
REQ-030 SHALL test: rd_ready=0, send 0x01..0x05 with A0=0 -> FIFO holds 0x01..0x04, overflow=1, frame_bytes=5; then rd_ready=1 -> pops 0x01,0x02,0x03,0x04 in order.
REQ-031 SHALL test: send 5 bits of 0xFF then raise CS -> frame_abort one cycle, no push; next frame 0x3C -> rd_data=0x3C.
REQ-032 SHALL test: full FIFO, rd_ready=1 on the cycle a byte completes -> count stays 4, overflow stays 0, new byte at tail.
REQ-033 SHALL test: overflow=1 and clr_ovf pulsed alone -> overflow=0 next cycle; clr_ovf coincident with new drop -> overflow remains 1.
REQ-034 SHALL test: rst_n low after 3 bits, released, send 0x81 -> rd_data=0x81 with no residue from prior bits.
